// File: rtl/hc138_rr_arbiter_pkg.sv
// hc_pkg: shared state encoding and constants for the hc138 round-robin arbiter
package hc_pkg;
  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;
  localparam int NUM_REQ = 8;
  localparam int IDX_W = 3;
  localparam logic [NUM_REQ-1:0] GRANT_NONE = 8'hFF;
endpackage

// File: rtl/hc138_rr_arbiter_sel_decoder.sv
// hc138_sel_decoder: combinational 3-to-8 active-low decoder (74HC138 style)
// ports: sel_i select index, g_i active-high enable, yn_o active-low one-hot (all high when disabled)
module hc138_sel_decoder
  import hc_pkg::*;
(
  input  logic [IDX_W-1:0]   sel_i,
  input  logic               g_i,
  output logic [NUM_REQ-1:0] yn_o
);
  always_comb yn_o = g_i ? ~(NUM_REQ'(1) << sel_i) : GRANT_NONE;
endmodule

// File: rtl/hc138_rr_arbiter.sv
// hc138_rr_arbiter: round-robin arbiter for 8 requesters with hold timeout, break-before-make gap and decoded active-low grants
// ports: clk_i/rst_i clock and sync active-high reset, en_i enable, req_i request vector, done_i release strobe,
//        grant_idx_o winner index, grant_n_o active-low grants, grant_vld_o grant active, timeout_p_o forced-release pulse
module hc138_rr_arbiter
  import hc_pkg::*;
#(
  parameter int MAX_HOLD   = 16,
  parameter int GAP_CYCLES = 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               en_i,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               done_i,
  output logic [IDX_W-1:0]   grant_idx_o,
  output logic [NUM_REQ-1:0] grant_n_o,
  output logic               grant_vld_o,
  output logic               timeout_p_o
);
  localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
  localparam logic [1:0] GAP_LAST = 2'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  state_t           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d, idx_q, idx_d, win;
  logic [HW-1:0]    hold_q, hold_d;
  logic [1:0]       gap_q, gap_d;
  logic             vld_q, vld_d, to_q, to_d, hit;
  logic             rel_to, rel;
  // scan from the highest offset down so the lowest offset from ptr wins
  always_comb begin
    win = '0;
    hit = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (req_i[ptr_q + IDX_W'(i)]) begin
        win = ptr_q + IDX_W'(i);
        hit = 1'b1;
      end
  end
  always_comb rel_to = (MAX_HOLD != 0) && (hold_q == HOLD_LAST);
  always_comb rel = done_i || !req_i[idx_q] || rel_to;
  always_ff @(posedge clk_i)
    if (rst_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      hold_q  <= '0;
      gap_q   <= '0;
      idx_q   <= '0;
      vld_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      gap_q   <= gap_d;
      idx_q   <= idx_d;
      vld_q   <= vld_d;
      to_q    <= to_d;
    end
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    gap_d   = gap_q;
    idx_d   = idx_q;
    vld_d   = vld_q;
    to_d    = 1'b0;
    case (state_q)
      IDLE:
        if (en_i && hit) begin
          state_d = GRANT;
          idx_d   = win;
          vld_d   = 1'b1;
          hold_d  = '0;
        end
      GRANT: begin
        hold_d = hold_q + HW'(1);
        if (rel) begin
          state_d = (GAP_CYCLES > 0) ? GAP : IDLE;
          vld_d   = 1'b0;
          ptr_d   = idx_q + IDX_W'(1);
          gap_d   = '0;
          // a voluntary release in the last allowed cycle is not a timeout
          to_d    = rel_to && !done_i && req_i[idx_q];
        end
      end
      GAP: begin
        gap_d   = gap_q + 2'd1;
        state_d = (gap_q == GAP_LAST) ? IDLE : GAP;
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    grant_idx_o = idx_q;
    grant_vld_o = vld_q;
    timeout_p_o = to_q;
  end
  hc138_sel_decoder u_dec (
    .sel_i (idx_q),
    .g_i   (vld_q),
    .yn_o  (grant_n_o)
  );
endmodule

// File: tb/tb_hc138_rr_arbiter.sv
// tb_hc138_rr_arbiter: table-driven scoreboard bench for hc138_rr_arbiter (MAX_HOLD=4, GAP_CYCLES=1)
module tb_hc138_rr_arbiter;
  typedef struct {
    logic       rst, en, done;
    logic [7:0] req;
    logic       vld;
    logic [2:0] idx;
    logic [7:0] n;
    logic       to;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, done = 1'b0;
  logic [7:0] req = '0;
  logic [2:0] gidx;
  logic [7:0] gn;
  logic gvld, gto;
  int checks = 0, errors = 0;
  vec_t tbl[$];
  vec_t exp_q[$];
  always #5 clk = ~clk;
  hc138_rr_arbiter #(.MAX_HOLD(4), .GAP_CYCLES(1)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .en_i        (en),
    .req_i       (req),
    .done_i      (done),
    .grant_idx_o (gidx),
    .grant_n_o   (gn),
    .grant_vld_o (gvld),
    .timeout_p_o (gto)
  );
  function automatic vec_t mk(logic r, logic e, logic [7:0] q, logic d, logic v, logic [2:0] i, logic [7:0] n, logic t);
    vec_t x;
    x.rst = r; x.en = e; x.req = q; x.done = d; x.vld = v; x.idx = i; x.n = n; x.to = t;
    return x;
  endfunction
  task automatic chk(string nm, int row, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h expected %h", nm, row, act, exp);
    end
  endtask
  initial begin
    vec_t e;
    int cnt, to_cnt, w;
    tbl.push_back(mk(1,0,8'h00,0, 0,0,8'hFF,0));
    tbl.push_back(mk(1,0,8'h00,0, 0,0,8'hFF,0));
    tbl.push_back(mk(0,1,8'h00,1, 0,0,8'hFF,0));
    tbl.push_back(mk(0,1,8'h08,0, 1,3,8'hF7,0));
    tbl.push_back(mk(0,1,8'h08,1, 0,3,8'hFF,0));
    tbl.push_back(mk(0,1,8'h08,0, 0,3,8'hFF,0));
    tbl.push_back(mk(0,1,8'h00,0, 0,3,8'hFF,0));
    tbl.push_back(mk(0,1,8'h81,0, 1,7,8'h7F,0));
    tbl.push_back(mk(0,1,8'h81,1, 0,7,8'hFF,0));
    tbl.push_back(mk(0,1,8'h81,0, 0,7,8'hFF,0));
    tbl.push_back(mk(0,1,8'h81,0, 1,0,8'hFE,0));
    tbl.push_back(mk(0,1,8'h81,1, 0,0,8'hFF,0));
    tbl.push_back(mk(0,1,8'h81,0, 0,0,8'hFF,0));
    tbl.push_back(mk(0,1,8'h81,0, 1,7,8'h7F,0));
    tbl.push_back(mk(0,1,8'h81,1, 0,7,8'hFF,0));
    tbl.push_back(mk(0,1,8'h81,0, 0,7,8'hFF,0));
    tbl.push_back(mk(0,1,8'h81,0, 1,0,8'hFE,0));
    tbl.push_back(mk(0,1,8'h00,1, 0,0,8'hFF,0));
    tbl.push_back(mk(0,1,8'h00,0, 0,0,8'hFF,0));
    tbl.push_back(mk(0,1,8'h00,0, 0,0,8'hFF,0));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0,1,8'h04,0, 1,2,8'hFB,0));
    tbl.push_back(mk(0,1,8'h04,0, 0,2,8'hFF,1));
    tbl.push_back(mk(0,1,8'h04,0, 0,2,8'hFF,0));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0,1,8'h04,0, 1,2,8'hFB,0));
    tbl.push_back(mk(0,1,8'h04,1, 0,2,8'hFF,0));
    tbl.push_back(mk(0,1,8'h00,0, 0,2,8'hFF,0));
    tbl.push_back(mk(0,0,8'hFF,0, 0,2,8'hFF,0));
    tbl.push_back(mk(0,0,8'hFF,0, 0,2,8'hFF,0));
    tbl.push_back(mk(0,1,8'hFF,0, 1,3,8'hF7,0));
    tbl.push_back(mk(0,1,8'hF7,0, 0,3,8'hFF,0));
    tbl.push_back(mk(0,1,8'hF7,0, 0,3,8'hFF,0));
    tbl.push_back(mk(0,1,8'hF7,0, 1,4,8'hEF,0));
    tbl.push_back(mk(0,0,8'hF7,0, 1,4,8'hEF,0));
    tbl.push_back(mk(0,0,8'hF7,1, 0,4,8'hFF,0));
    tbl.push_back(mk(0,0,8'hF7,0, 0,4,8'hFF,0));
    tbl.push_back(mk(0,0,8'hF7,0, 0,4,8'hFF,0));
    tbl.push_back(mk(0,1,8'h20,0, 1,5,8'hDF,0));
    tbl.push_back(mk(1,1,8'h21,0, 0,0,8'hFF,0));
    tbl.push_back(mk(0,1,8'h21,0, 1,0,8'hFE,0));
    tbl.push_back(mk(0,1,8'h21,1, 0,0,8'hFF,0));
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      rst = tbl[i].rst; en = tbl[i].en; req = tbl[i].req; done = tbl[i].done;
      exp_q.push_back(tbl[i]);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      chk("vld", i, 8'(gvld), 8'(e.vld));
      chk("idx", i, 8'(gidx), 8'(e.idx));
      chk("grant_n", i, gn, e.n);
      chk("timeout", i, 8'(gto), 8'(e.to));
    end
    @(negedge clk);
    rst = 1'b0; en = 1'b1; done = 1'b0; req = 8'h40;
    w = 0;
    while (!gvld && w < 10) begin
      @(posedge clk);
      #1;
      w++;
    end
    chk("seq_grant_seen", 100, 8'(gvld), 8'd1);
    chk("seq_idx", 100, 8'(gidx), 8'd6);
    chk("seq_n", 100, gn, 8'hBF);
    cnt = gvld ? 1 : 0;
    to_cnt = 0;
    for (int k = 0; k < 20 && gvld; k++) begin
      @(posedge clk);
      #1;
      if (gto) to_cnt++;
      if (gvld) cnt++;
    end
    chk("seq_hold_len", 101, 8'(cnt), 8'd4);
    chk("seq_to_pulses", 101, 8'(to_cnt), 8'd1);
    @(posedge clk);
    #1;
    chk("seq_to_clear", 102, 8'(gto), 8'd0);
    chk("seq_gap_idle", 102, gn, 8'hFF);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/hc138_rr_arbiter.md
Name: hc138_rr_arbiter

Overview:
- Round-robin arbiter that shares one 3-to-8 decoded select bus between 8 requesters.
- Registers a 3-bit winner index and drives it through a 74HC138-style decode to produce active-low one-hot grant lines, the same convention as the board's decoder outputs.
- Enforces grant hold, release, timeout and a break-before-make gap between successive grants.
- Sits between the requesting blocks and the shared bus or chip-select fan-out.

Parameters:
- MAX_HOLD, 16, maximum cycles a grant may be held before forced release; 0 disables the timeout.
- GAP_CYCLES, 1, idle cycles with all grants deasserted between a release and the next grant; legal range 0..3.

Ports:
- Clk  in  1  single system clock, rising edge.
- Rst  in  1  synchronous, active-high reset.
- En  in  1  arbiter enable; when low, no new grant is issued.
- Req  in  8  request vector; bit i is requester i, held high until served.
- Done  in  1  release strobe from the current grantee, sampled only while GrantVld=1.
- GrantIdx  out  3  registered index of the current grantee.
- GrantN  out  8  active-low one-hot grant; 8'hFF when no grant is active.
- GrantVld  out  1  high while a grant is active.
- TimeoutP  out  1  one-cycle pulse when a grant is force-released by MAX_HOLD.

Behaviour:
- Reset values (next edge with Rst=1, from any state including mid-grant):
  - state=IDLE, Ptr=0, HoldCnt=0, GapCnt=0.
  - GrantIdx=0, GrantN=8'hFF, GrantVld=0, TimeoutP=0.
- All outputs are registered. GrantN = ~(GrantVld << GrantIdx), produced by the decoder sub-module from registered values only, so it is glitch-free.
- IDLE:
  - Condition: En=1 and |Req.
  - Selection: the first set bit searching Ptr, Ptr+1 … 7, 0 … Ptr-1, with mod-8 wrap.
  - Result: next cycle GrantIdx=winner, GrantVld=1, state GRANT, HoldCnt=0.
  - Latency: 1 cycle from the sampled request to the visible grant.
- GRANT: HoldCnt increments every cycle. Release conditions, in priority order:
  - (a) Done=1: normal release.
  - (b) Req[GrantIdx]=0: implicit release.
  - (c) MAX_HOLD≠0 and HoldCnt==MAX_HOLD-1: forced release, TimeoutP=1 for the next cycle.
  - If (a) or (b) coincides with (c), there is no TimeoutP.
- On release:
  - Next cycle GrantVld=0 and GrantN=8'hFF.
  - Ptr=(GrantIdx+1) mod 8, so 7 wraps to 0.
  - GrantIdx keeps its last value.
  - Next state is GAP if GAP_CYCLES>0, otherwise IDLE.
- A grant therefore lasts at most MAX_HOLD cycles.
- GAP:
  - Stays for GAP_CYCLES cycles with outputs deasserted, then goes to IDLE.
  - Requests arriving during GAP are not lost; they are arbitrated in IDLE.
  - With GAP_CYCLES=0, a new grant is visible 1 cycle after GrantVld falls (IDLE evaluation).
- En=0:
  - Never aborts an active grant; the grant completes normally.
  - Blocks the IDLE→GRANT transition.
  - Ptr is unchanged while blocked.
- Req=0 in IDLE: remain in IDLE.
- Done while GrantVld=0: ignored.
- HoldCnt width: $clog2(MAX_HOLD+1), minimum 1.

Decomposition:
- Shared package hc_pkg:
  - state enum {IDLE, GRANT, GAP}.
  - Constants: NUM_REQ=8, IDX_W=3, GRANT_NONE=8'hFF.
- One sub-module, hc138_sel_decoder: purely combinational 3-to-8 active-low decoder.
  - Inputs: Sel[2:0] and enable G (active-high).
  - Output: Yn[7:0].
  - The arbiter instantiates it with Sel=GrantIdx, G=GrantVld.
- Round-robin priority search and FSM stay in the top module.

Test Plan:
- Reset/idle: Rst=1 for 2 cycles, Req=8'h00 → GrantN=8'hFF, GrantVld=0, GrantIdx=0; after Rst falls, outputs stay idle.
- Basic grant/release: Req=8'h08 → next cycle GrantIdx=3, GrantN=8'hF7; Done pulse → next cycle GrantN=8'hFF; with GAP_CYCLES=1 the bus is idle for 1 extra cycle.
- Round-robin fairness and wrap-around: Req=8'h81 held, each grant released by Done → grants alternate 0,7,0,7; after grantee 7, Ptr=0.
- Timeout: MAX_HOLD=4, Req=8'h04, no Done → GrantVld high for exactly 4 cycles, TimeoutP=1 for one cycle; Done in the 4th cycle → no TimeoutP.
- Enable and implicit release: En=0 with Req=8'hFF → no grant; En=1 → grant 0; drop Req[0] → release, then grant 1 after the gap; En=0 mid-grant → grant completes.
- Reset mid-grant: Rst=1 while GrantIdx=5 → next edge GrantN=8'hFF and Ptr=0; with Req=8'h21 after reset, requester 0 is granted first.
